// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with a ready-handshaked memory port.
// Define MULTICYCLE_CTRL_BNE_EN to decode BNE; without it opcode 0x05 is illegal.
module multicycle_ctrl #(
    parameter int unsigned OPW  = 6,
    parameter int unsigned ALUW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            pcen,
    output logic            iord,
    output logic            memtoreg,
    output logic            pcsrc,
    output logic            alusrca,
    output logic            memwrite,
    output logic            irwrite,
    output logic            regwrite,
    output logic [1:0]      alusrcb,
    output logic [ALUW-1:0] alucontrol,
    output logic            illegal,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'h23);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'h2B);

    localparam logic [ALUW-1:0] ALU_ADD   = '0;
    localparam logic [ALUW-1:0] ALU_SUB   = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_FUNCT = '1;

    state_e state_q, state_d;
    logic   run_q, run_d;
    logic   pcwrite, branch, taken;

    // Full-width compares, so any nonzero bit above [5:0] prevents a match.
    logic is_rtype, is_j, is_beq, is_bne, is_addi, is_lw, is_sw;
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_j     = (opcode == OP_J);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
`ifdef MULTICYCLE_CTRL_BNE_EN
    assign is_bne   = (opcode == OPW'(6'h05));
`else
    assign is_bne   = 1'b0;
`endif

    // run_q holds the FSM idle for one cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 1'b0;
        alusrca    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrcb    = 2'd0;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;

        if (!run_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'd1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alusrcb = 2'd3;
                    if (is_lw || is_sw)        state_d = S_MEMADR;
                    else if (is_rtype)         state_d = S_EXEC;
                    else if (is_beq || is_bne) state_d = S_BRANCH;
                    else if (is_addi)          state_d = S_ADDIEX;
                    else if (is_j)             state_d = S_JUMP;
                    else begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'd2;
                    if (is_lw)      state_d = S_MEMRD;
                    else if (is_sw) state_d = S_MEMWR;
                    else            state_d = S_FETCH;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXEC: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_FUNCT;
                    state_d    = S_ALUWB;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 1'b1;
                    branch     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'd2;
                    state_d = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_JUMP: begin
                    pcsrc   = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end

        taken = (is_beq && zero) || (is_bne && !zero);
        pcen  = pcwrite || (branch && taken);
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl against an instruction-path model.
module tb_multicycle_ctrl;

    localparam int unsigned OPW  = 6;
    localparam int unsigned ALUW = 3;

    localparam int unsigned F  = 0,  D  = 1,  MA = 2,  MR = 3,  MB = 4,  MW = 5;
    localparam int unsigned EX = 6,  AW = 7,  BR = 8,  IE = 9,  IW = 10, JP = 11;

    logic            clk;
    logic            reset;
    logic [OPW-1:0]  opcode;
    logic            zero;
    logic            mem_ready;
    logic            mem_req, pcen, iord, memtoreg, pcsrc, alusrca;
    logic            memwrite, irwrite, regwrite, illegal;
    logic [1:0]      alusrcb;
    logic [ALUW-1:0] alucontrol;
    logic [3:0]      state;

    multicycle_ctrl #(.OPW(OPW), .ALUW(ALUW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .pcen(pcen), .iord(iord), .memtoreg(memtoreg), .pcsrc(pcsrc),
        .alusrca(alusrca), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      st;
        logic            mem_req, pcen, iord, memtoreg, pcsrc, alusrca;
        logic            memwrite, irwrite, regwrite;
        logic [1:0]      alusrcb;
        logic [ALUW-1:0] aluc;
        logic            illegal;
    } obs_t;

    obs_t        sb[$];
    int unsigned path[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [5:0]  next_op;
    logic        was_rst;
    logic        op_illegal;
    int unsigned last_st;
    obs_t        mon_exp, mon_got;

    function automatic obs_t observe();
        obs_t o;
        o.st = state;             o.mem_req = mem_req;   o.pcen = pcen;
        o.iord = iord;            o.memtoreg = memtoreg; o.pcsrc = pcsrc;
        o.alusrca = alusrca;      o.memwrite = memwrite; o.irwrite = irwrite;
        o.regwrite = regwrite;    o.alusrcb = alusrcb;   o.aluc = alucontrol;
        o.illegal = illegal;
        return o;
    endfunction

    // Fixed strobes of each step of an instruction; handshake-dependent bits added in step().
    function automatic obs_t base(input int unsigned s);
        obs_t o;
        o = '0;
        o.st = 4'(s);
        case (s)
            F:  begin o.mem_req = 1'b1; o.alusrcb = 2'd1; end
            D:  o.alusrcb = 2'd3;
            MA: begin o.alusrca = 1'b1; o.alusrcb = 2'd2; end
            MR: begin o.mem_req = 1'b1; o.iord = 1'b1; end
            MB: begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
            MW: begin o.mem_req = 1'b1; o.iord = 1'b1; o.memwrite = 1'b1; end
            EX: begin o.alusrca = 1'b1; o.aluc = '1; end
            AW: o.regwrite = 1'b1;
            BR: begin o.alusrca = 1'b1; o.aluc = ALUW'(1); o.pcsrc = 1'b1; end
            IE: begin o.alusrca = 1'b1; o.alusrcb = 2'd2; end
            IW: o.regwrite = 1'b1;
            JP: begin o.pcsrc = 1'b1; o.pcen = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic load_path(input logic [5:0] op);
        path.delete();
        path.push_back(F);
        path.push_back(D);
        case (op)
            6'h00: begin path.push_back(EX); path.push_back(AW); end
            6'h23: begin path.push_back(MA); path.push_back(MR); path.push_back(MB); end
            6'h2B: begin path.push_back(MA); path.push_back(MW); end
            6'h04: path.push_back(BR);
`ifdef MULTICYCLE_CTRL_BNE_EN
            6'h05: path.push_back(BR);
`endif
            6'h08: begin path.push_back(IE); path.push_back(IW); end
            6'h02: path.push_back(JP);
            default: ;
        endcase
        op_illegal = (path.size() == 2);
    endtask

    function automatic int unsigned peek();
        return (path.size() == 0) ? F : path[0];
    endfunction

    // One clock of stimulus; pushes the cycle's expected outputs.
    task automatic step(input logic rst, input logic rdy, input logic zr);
        obs_t        e;
        int unsigned s;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = rdy;
        zero      = zr;
        if (!rst) begin
            path.delete();
            was_rst = 1'b1;
            e = '0;
        end else if (was_rst) begin
            was_rst = 1'b0;
            e = '0;
        end else begin
            if (path.size() == 0) begin
                opcode = next_op;
                load_path(next_op);
            end
            s = path[0];
            e = base(s);
            if (s == F) begin e.irwrite = rdy; e.pcen = rdy; end
            if (s == BR) e.pcen = (opcode == 6'h04) ? zr : !zr;
            if (s == D) e.illegal = op_illegal;
            if (!((s == F || s == MR || s == MW) && !rdy)) void'(path.pop_front());
            last_st = s;
        end
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [5:0] op, input logic zr);
        next_op = op;
        step(1'b1, 1'b1, zr);
        for (int i = 0; i < 10 && path.size() != 0; i++) step(1'b1, 1'b1, zr);
    endtask

    function automatic logic [5:0] pick();
        case ($urandom_range(0, 9))
            0: return 6'h00;
            1: return 6'h02;
            2: return 6'h04;
            3: return 6'h08;
            4: return 6'h23;
            5: return 6'h2B;
            6: return 6'h05;
            7: return 6'h3F;
            8: return 6'h23;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                mon_got = observe();
                n_checks++;
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL outputs st=%0d: got %h expected %h", mon_exp.st, mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        logic rdy;
        int   waits;
        bit   reached;
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = '0;
        next_op = 6'h00; was_rst = 1'b0; op_illegal = 1'b0; last_st = F;

        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_op(6'h00, 1'b0);
        run_op(6'h04, 1'b1);
        run_op(6'h04, 1'b0);
        run_op(6'h05, 1'b1);
        run_op(6'h05, 1'b0);
        run_op(6'h3F, 1'b0);
        run_op(6'h02, 1'b0);
        run_op(6'h08, 1'b1);

        // LW held three cycles in the read
        next_op = 6'h23;
        waits = 0;
        for (int i = 0; i < 20; i++) begin
            rdy = !(peek() == MR && waits < 3);
            if (!rdy) waits++;
            step(1'b1, rdy, 1'b0);
            if (path.size() == 0) break;
        end
        check("lw_waits", 32'(waits), 3);

        // Store stalled in MEMWR, then reset arrives mid-cycle
        next_op = 6'h2B;
        reached = 1'b0;
        last_st = F;
        for (int i = 0; i < 20 && !reached; i++) begin
            rdy = (peek() != MW);
            step(1'b1, rdy, 1'b0);
            if (last_st == MW) reached = 1'b1;
        end
        check("reach_memwr", 32'(reached), 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_memwrite", 32'(memwrite), 0);
        check("async_mem_req", 32'(mem_req), 0);
        check("async_state", 32'(state), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        run_op(6'h00, 1'b0);

        for (int i = 0; i < 800; i++) begin
            if (path.size() == 0) next_op = pick();
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OPW, default 6: opcode width (>=6); bits above [5:0] SHALL be zero for any opcode to match.
REQ-002 Parameter ALUW, default 3: alucontrol width (>=2).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 opcode  input  OPW  instruction opcode from IR.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 mem_req  output  1  memory access in progress.
REQ-009 pcen, iord, memtoreg, pcsrc, alusrca, memwrite, irwrite, regwrite  output  1 each  datapath strobes and selects.
REQ-010 alusrcb  output  2  ALU B select: 0=reg, 1=const 4, 2=imm, 3=imm<<2.
REQ-011 alucontrol  output  ALUW  0=ADD, 1=SUB, all-ones=FUNCT (decode funct downstream).
REQ-012 illegal  output  1  one-cycle pulse on an undecodable opcode.
REQ-013 state  output  4  current FSM state, for debug.

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-015 Opcodes: RTYPE=0x00, J=0x02, BEQ=0x04, BNE=0x05, ADDI=0x08, LW=0x23, SW=0x2B.
REQ-016 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=1, ADD; when mem_ready=1, irwrite=1, pcwrite=1, next DECODE; otherwise hold FETCH with irwrite=pcwrite=0.
REQ-017 DECODE: alusrca=0, alusrcb=3, ADD; next by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ/BNE->BRANCH, ADDI->ADDIEX, J->JUMP; any other opcode -> FETCH with illegal=1 for that cycle.
REQ-018 MEMADR: alusrca=1, alusrcb=2, ADD; next MEMRD for LW, MEMWR for SW.
REQ-019 MEMRD: mem_req=1, iord=1; next MEMWB when mem_ready=1, else hold.
REQ-020 MEMWR: mem_req=1, iord=1, memwrite=1 while held; next FETCH when mem_ready=1.
REQ-021 MEMWB: regwrite=1, memtoreg=1; next FETCH.
REQ-022 EXEC: alusrca=1, alusrcb=0, FUNCT; next ALUWB (regwrite=1, memtoreg=0), then FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=2, ADD; next ADDIWB (regwrite=1), then FETCH.
REQ-024 BRANCH: alusrca=1, alusrcb=0, SUB, pcsrc=1; taken = zero for BEQ, ~zero for BNE; next FETCH.
REQ-025 JUMP: pcsrc=1, pcwrite=1; next FETCH.
REQ-026 pcen SHALL equal pcwrite | (branch & taken), combinational within the state.
REQ-027 Outputs not listed for a state SHALL be 0; alusrcb and alucontrol default to 0.
REQ-028 Unused high bits of alucontrol (ALUW>2) SHALL be 0 except in FUNCT encoding.
REQ-029 mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.

Reset
REQ-030 While reset=0, state SHALL be FETCH, illegal=0, and all registered outputs 0; release is synchronised internally by one flop.
REQ-031 Reset asserted mid-access (MEMRD/MEMWR/FETCH waiting) SHALL abort the access immediately; memwrite and mem_req SHALL drop asynchronously.

Configuration
REQ-032 Macro MULTICYCLE_CTRL_BNE_EN: when defined, BNE is decoded as in REQ-017/REQ-024.
REQ-033 Without MULTICYCLE_CTRL_BNE_EN, opcode 0x05 SHALL be illegal (illegal pulse, return to FETCH); no other behaviour changes.

Verification
REQ-034 Reset low, then high with mem_ready=1, opcode=0x00 -> FETCH(pcen=1, irwrite=1), DECODE, EXEC(alucontrol=all-ones), ALUWB(regwrite=1), FETCH: 4 cycles per instruction.
REQ-035 LW with mem_ready low for 3 cycles in MEMRD -> state holds 3 at mem_req=1 for 3 cycles, then MEMWB with regwrite=1, memtoreg=1.
REQ-036 BEQ zero=1 -> pcen=1 in BRANCH; zero=0 -> pcen=0; with MULTICYCLE_CTRL_BNE_EN, BNE gives the inverse.
REQ-037 opcode=0x3F in DECODE -> illegal=1 one cycle, next state FETCH, no regwrite/memwrite; without the macro, 0x05 behaves identically.
REQ-038 Reset asserted during MEMWR with memwrite=1 -> memwrite, mem_req 0 same cycle, state=0; after release, FETCH.
